// File: rtl/segasys1_pkg.sv
// Shared types and constants for the System 1 load sequencer.
// Used by the top-level FSM and the ioctl write demux.
package segasys1_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2,
        RUN  = 2'd3
    } load_state_t;

    localparam int SYSMODE_SYS2_BIT = 0;
    localparam int SYSMODE_VERT_BIT = 1;
    localparam int SYSMODE_H240_BIT = 2;

    localparam logic [7:0] ROM_INDEX_DEF  = 8'd0;
    localparam logic [7:0] MODE_INDEX_DEF = 8'd1;
    localparam logic [7:0] DSW_INDEX_DEF  = 8'd254;

endpackage

// File: rtl/segasys1_load_ctrl_demux.sv
// Registered decode of ioctl byte writes into ROM strobes,
// the SYSMODE byte and the 8-byte DIP-switch bank.
module ioctl_demux
    import segasys1_pkg::*;
#(
    parameter logic [7:0] ROM_INDEX  = ROM_INDEX_DEF,
    parameter logic [7:0] MODE_INDEX = MODE_INDEX_DEF,
    parameter logic [7:0] DSW_INDEX  = DSW_INDEX_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        dl_i,
    input  logic        wr_i,
    input  logic [7:0]  index_i,
    input  logic [24:0] addr_i,
    input  logic [7:0]  dout_i,
    output logic        rom_we_o,
    output logic [24:0] rom_addr_o,
    output logic [7:0]  rom_data_o,
    output logic [7:0]  sysmode_o,
    output logic [63:0] dsw_o
);

    logic        rom_we_q, rom_we_d;
    logic [24:0] rom_addr_q, rom_addr_d;
    logic [7:0]  rom_data_q, rom_data_d;
    logic [7:0]  sysmode_q, sysmode_d;
    logic [63:0] dsw_q, dsw_d;
    logic        strobe;

    assign strobe = wr_i & dl_i;

    // Next-state decode of a single accepted write strobe
    always_comb begin
        rom_we_d   = 1'b0;
        rom_addr_d = rom_addr_q;
        rom_data_d = rom_data_q;
        sysmode_d  = sysmode_q;
        dsw_d      = dsw_q;
        if (strobe) begin
            if (index_i == ROM_INDEX) begin
                rom_we_d   = 1'b1;
                rom_addr_d = addr_i;
                rom_data_d = dout_i;
            end
            if (index_i == MODE_INDEX && addr_i == 25'd0) begin
                sysmode_d = dout_i;
            end
            if (index_i == DSW_INDEX && addr_i[24:3] == 22'd0) begin
                dsw_d[{addr_i[2:0], 3'b000} +: 8] = dout_i;
            end
        end
    end

    // Output registers; addr/data hold their last written value
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rom_we_q   <= 1'b0;
            rom_addr_q <= '0;
            rom_data_q <= '0;
            sysmode_q  <= '0;
            dsw_q      <= '0;
        end else begin
            rom_we_q   <= rom_we_d;
            rom_addr_q <= rom_addr_d;
            rom_data_q <= rom_data_d;
            sysmode_q  <= sysmode_d;
            dsw_q      <= dsw_d;
        end
    end

    assign rom_we_o   = rom_we_q;
    assign rom_addr_o = rom_addr_q;
    assign rom_data_o = rom_data_q;
    assign sysmode_o  = sysmode_q;
    assign dsw_o      = dsw_q;

endmodule

// File: rtl/segasys1_load_ctrl.sv
// Load sequencer: keeps the game core in reset during ROM load
// and a fixed hold-off after it, folding in user resets.
module segasys1_load_ctrl
    import segasys1_pkg::*;
#(
    parameter logic [7:0] ROM_INDEX  = ROM_INDEX_DEF,
    parameter logic [7:0] MODE_INDEX = MODE_INDEX_DEF,
    parameter logic [7:0] DSW_INDEX  = DSW_INDEX_DEF,
    parameter int         HOLD_CYC   = 1024
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_index,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        user_reset,
    output logic        rom_we,
    output logic [24:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic [7:0]  sysmode,
    output logic [63:0] dsw,
    output logic        core_reset,
    output logic        ready
);

    localparam int CW = $clog2(HOLD_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYC - 1);

    load_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ready_q, ready_d;
    logic          core_reset_q;
    logic          rom_dl;

    assign rom_dl = ioctl_download & (ioctl_index == ROM_INDEX);

    ioctl_demux #(
        .ROM_INDEX  (ROM_INDEX),
        .MODE_INDEX (MODE_INDEX),
        .DSW_INDEX  (DSW_INDEX)
    ) u_demux (
        .clk_i      (clk_sys),
        .rst_ni     (reset_n),
        .dl_i       (ioctl_download),
        .wr_i       (ioctl_wr),
        .index_i    (ioctl_index),
        .addr_i     (ioctl_addr),
        .dout_i     (ioctl_dout),
        .rom_we_o   (rom_we),
        .rom_addr_o (rom_addr),
        .rom_data_o (rom_data),
        .sysmode_o  (sysmode),
        .dsw_o      (dsw)
    );

    // Next state, hold-off counter and sticky ready flag
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        unique case (state_q)
            BOOT: begin
                if (rom_dl) state_d = LOAD;
            end
            LOAD: begin
                if (!ioctl_download) begin
                    cnt_d   = '0;
                    ready_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (rom_dl) begin
                    state_d = LOAD;
                end else if (user_reset) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (rom_dl) begin
                    state_d = LOAD;
                end else if (user_reset) begin
                    cnt_d   = '0;
                    state_d = HOLD;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // State, counter, ready and core reset registers
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= BOOT;
            cnt_q        <= '0;
            ready_q      <= 1'b0;
            core_reset_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
            core_reset_q <= (state_q != RUN);
        end
    end

    assign core_reset = core_reset_q;
    assign ready      = ready_q;

endmodule

// File: tb/tb_segasys1_load_ctrl.sv
// Directed bench for segasys1_load_ctrl: table-driven write
// vectors plus hand sequences for hold-off and reset timing.
module tb_segasys1_load_ctrl;
    import segasys1_pkg::*;

    localparam int HC = 16;

    typedef struct {
        logic        dl;
        logic        wr;
        logic [7:0]  idx;
        logic [24:0] addr;
        logic [7:0]  dout;
        logic        ur;
        logic        we;
        logic [24:0] ra;
        logic [7:0]  rd;
        logic [7:0]  sm;
        logic [63:0] dsw;
        logic        cr;
        logic        rdy;
    } vec_t;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic [24:0] ioctl_addr = 25'd0;
    logic [7:0]  ioctl_dout = 8'd0;
    logic        user_reset = 1'b0;
    logic        rom_we;
    logic [24:0] rom_addr;
    logic [7:0]  rom_data;
    logic [7:0]  sysmode;
    logic [63:0] dsw;
    logic        core_reset;
    logic        ready;

    int checks = 0;
    int errors = 0;
    vec_t tbl [18];

    segasys1_load_ctrl #(.HOLD_CYC(HC)) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_index    (ioctl_index),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .user_reset     (user_reset),
        .rom_we         (rom_we),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .sysmode        (sysmode),
        .dsw            (dsw),
        .core_reset     (core_reset),
        .ready          (ready)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic vec_t mk(
        input logic dl, input logic wr, input logic [7:0] idx,
        input logic [24:0] addr, input logic [7:0] dout,
        input logic ur, input logic we, input logic [24:0] ra,
        input logic [7:0] rd, input logic [7:0] sm,
        input logic [63:0] dw, input logic cr, input logic rdy);
        vec_t v;
        v.dl = dl; v.wr = wr; v.idx = idx; v.addr = addr;
        v.dout = dout; v.ur = ur; v.we = we; v.ra = ra;
        v.rd = rd; v.sm = sm; v.dsw = dw; v.cr = cr; v.rdy = rdy;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic dl, input logic wr,
                         input logic [7:0] idx, input logic [24:0] addr,
                         input logic [7:0] dout, input logic ur);
        ioctl_download = dl;
        ioctl_wr       = wr;
        ioctl_index    = idx;
        ioctl_addr     = addr;
        ioctl_dout     = dout;
        user_reset     = ur;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = tbl[i];
        drive(v.dl, v.wr, v.idx, v.addr, v.dout, v.ur);
        chk($sformatf("v%0d.rom_we", i), 64'(rom_we), 64'(v.we));
        chk($sformatf("v%0d.rom_addr", i), 64'(rom_addr), 64'(v.ra));
        chk($sformatf("v%0d.rom_data", i), 64'(rom_data), 64'(v.rd));
        chk($sformatf("v%0d.sysmode", i), 64'(sysmode), 64'(v.sm));
        chk($sformatf("v%0d.dsw", i), dsw, v.dsw);
        chk($sformatf("v%0d.core_reset", i), 64'(core_reset), 64'(v.cr));
        chk($sformatf("v%0d.ready", i), 64'(ready), 64'(v.rdy));
    endtask

    // Idle n cycles; core_reset must stay high until the last one
    task automatic expect_fall(input string nm, input int n);
        for (int k = 1; k <= n; k++) begin
            drive(1'b0, 1'b0, 8'd0, 25'd0, 8'd0, 1'b0);
            chk($sformatf("%s.cr%0d", nm, k), 64'(core_reset),
                (k < n) ? 64'd1 : 64'd0);
        end
        chk({nm, ".ready"}, 64'(ready), 64'd1);
    endtask

    initial begin
        tbl[0]  = mk(1, 0, 8'd0,   25'd0, 8'h00, 0, 0, 25'd0, 8'h00, 8'h00, 64'h0, 1, 0);
        tbl[1]  = mk(1, 1, 8'd0,   25'd0, 8'hA0, 0, 1, 25'd0, 8'hA0, 8'h00, 64'h0, 1, 0);
        tbl[2]  = mk(1, 1, 8'd0,   25'd1, 8'hA1, 0, 1, 25'd1, 8'hA1, 8'h00, 64'h0, 1, 0);
        tbl[3]  = mk(1, 1, 8'd0,   25'd2, 8'hA2, 0, 1, 25'd2, 8'hA2, 8'h00, 64'h0, 1, 0);
        tbl[4]  = mk(1, 1, 8'd0,   25'd3, 8'hA3, 0, 1, 25'd3, 8'hA3, 8'h00, 64'h0, 1, 0);
        tbl[5]  = mk(1, 0, 8'd0,   25'd3, 8'h00, 0, 0, 25'd3, 8'hA3, 8'h00, 64'h0, 1, 0);
        tbl[6]  = mk(0, 0, 8'd0,   25'd0, 8'h00, 0, 0, 25'd3, 8'hA3, 8'h00, 64'h0, 1, 1);
        tbl[7]  = mk(1, 1, 8'd1,   25'd0, 8'h06, 0, 0, 25'd3, 8'hA3, 8'h06, 64'h0, 0, 1);
        tbl[8]  = mk(1, 1, 8'd254, 25'd2, 8'h5A, 0, 0, 25'd3, 8'hA3, 8'h06,
                     64'h0000_0000_005A_0000, 0, 1);
        tbl[9]  = mk(0, 1, 8'd0,   25'd7, 8'hFF, 0, 0, 25'd3, 8'hA3, 8'h06,
                     64'h0000_0000_005A_0000, 0, 1);
        tbl[10] = mk(0, 1, 8'd1,   25'd0, 8'h55, 0, 0, 25'd3, 8'hA3, 8'h06,
                     64'h0000_0000_005A_0000, 0, 1);
        tbl[11] = mk(0, 1, 8'd254, 25'd0, 8'h11, 0, 0, 25'd3, 8'hA3, 8'h06,
                     64'h0000_0000_005A_0000, 0, 1);
        tbl[12] = mk(1, 1, 8'd254, 25'd8, 8'h77, 0, 0, 25'd3, 8'hA3, 8'h06,
                     64'h0000_0000_005A_0000, 0, 1);
        tbl[13] = mk(1, 1, 8'd254, 25'd0, 8'h11, 0, 0, 25'd3, 8'hA3, 8'h06,
                     64'h0000_0000_005A_0011, 0, 1);
        tbl[14] = mk(1, 1, 8'd254, 25'd7, 8'hC3, 0, 0, 25'd3, 8'hA3, 8'h06,
                     64'hC300_0000_005A_0011, 0, 1);
        tbl[15] = mk(1, 1, 8'd2,   25'd0, 8'h99, 0, 0, 25'd3, 8'hA3, 8'h06,
                     64'hC300_0000_005A_0011, 0, 1);
        tbl[16] = mk(1, 1, 8'd1,   25'd1, 8'h99, 0, 0, 25'd3, 8'hA3, 8'h06,
                     64'hC300_0000_005A_0011, 0, 1);
        tbl[17] = mk(0, 0, 8'd0,   25'd0, 8'h00, 0, 0, 25'd3, 8'hA3, 8'h06,
                     64'hC300_0000_005A_0011, 0, 1);

        // Reset state
        repeat (2) @(posedge clk_sys);
        #1;
        chk("rst.core_reset", 64'(core_reset), 64'd1);
        chk("rst.ready", 64'(ready), 64'd0);
        chk("rst.rom_we", 64'(rom_we), 64'd0);
        chk("rst.state", 64'(dut.state_q), 64'(BOOT));
        @(negedge clk_sys);
        reset_n = 1'b1;
        @(posedge clk_sys);
        #1;

        // Non-ROM download and user reset do not leave BOOT
        drive(1'b1, 1'b0, 8'd1, 25'd0, 8'h00, 1'b1);
        drive(1'b0, 1'b0, 8'd0, 25'd0, 8'h00, 1'b1);
        chk("boot.state", 64'(dut.state_q), 64'(BOOT));
        chk("boot.core_reset", 64'(core_reset), 64'd1);

        // ROM load of 4 bytes, then hold-off
        for (int i = 0; i <= 6; i++) run_vec(i);
        expect_fall("load1", HC + 1);

        // SYSMODE/DSW writes and ignored strobes in RUN
        for (int i = 7; i <= 17; i++) run_vec(i);

        // User reset held 10 cycles in RUN
        for (int k = 1; k <= 10; k++) begin
            drive(1'b0, 1'b0, 8'd0, 25'd0, 8'h00, 1'b1);
            chk($sformatf("ureset.cr%0d", k), 64'(core_reset),
                (k == 1) ? 64'd0 : 64'd1);
        end
        expect_fall("ureset", HC + 1);
        chk("ureset.rom_we", 64'(rom_we), 64'd0);

        // ROM download from RUN, restarted mid-HOLD
        drive(1'b1, 1'b0, 8'd0, 25'd0, 8'h00, 1'b0);
        chk("rerun.cr_lag", 64'(core_reset), 64'd0);
        drive(1'b1, 1'b1, 8'd0, 25'd10, 8'h5C, 1'b0);
        chk("rerun.cr", 64'(core_reset), 64'd1);
        chk("rerun.rom_addr", 64'(rom_addr), 64'd10);
        chk("rerun.rom_data", 64'(rom_data), 64'h5C);
        drive(1'b0, 1'b0, 8'd0, 25'd0, 8'h00, 1'b0);
        repeat (5) drive(1'b0, 1'b0, 8'd0, 25'd0, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 8'd0, 25'd0, 8'h00, 1'b0);
        chk("restart.state", 64'(dut.state_q), 64'(LOAD));
        drive(1'b1, 1'b1, 8'd0, 25'd11, 8'hC5, 1'b0);
        chk("restart.rom_we", 64'(rom_we), 64'd1);
        chk("restart.cr", 64'(core_reset), 64'd1);
        drive(1'b0, 1'b0, 8'd0, 25'd0, 8'h00, 1'b0);
        expect_fall("restart", HC + 1);

        // ROM download and user reset together in RUN: LOAD wins
        drive(1'b1, 1'b0, 8'd0, 25'd0, 8'h00, 1'b1);
        drive(1'b1, 1'b0, 8'd0, 25'd0, 8'h00, 1'b1);
        chk("both.state", 64'(dut.state_q), 64'(LOAD));
        drive(1'b0, 1'b0, 8'd0, 25'd0, 8'h00, 1'b0);
        expect_fall("both", HC + 1);

        // Async reset in the middle of a ROM load
        drive(1'b1, 1'b0, 8'd0, 25'd0, 8'h00, 1'b0);
        drive(1'b1, 1'b1, 8'd0, 25'd5, 8'hE7, 1'b0);
        chk("midload.rom_we", 64'(rom_we), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst.core_reset", 64'(core_reset), 64'd1);
        chk("arst.ready", 64'(ready), 64'd0);
        chk("arst.rom_we", 64'(rom_we), 64'd0);
        chk("arst.rom_addr", 64'(rom_addr), 64'd0);
        chk("arst.rom_data", 64'(rom_data), 64'd0);
        chk("arst.sysmode", 64'(sysmode), 64'd0);
        chk("arst.dsw", dsw, 64'd0);
        chk("arst.state", 64'(dut.state_q), 64'(BOOT));
        ioctl_download = 1'b0;
        ioctl_wr = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        drive(1'b0, 1'b0, 8'd0, 25'd0, 8'h00, 1'b1);
        chk("post.state", 64'(dut.state_q), 64'(BOOT));
        chk("post.ready", 64'(ready), 64'd0);
        drive(1'b1, 1'b0, 8'd0, 25'd0, 8'h00, 1'b0);
        chk("post.load", 64'(dut.state_q), 64'(LOAD));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/segasys1_load_ctrl.md
# segasys1_load_ctrl

Sequencer between the HPS download port and the System 1 game core. It demultiplexes the ioctl byte stream into ROM writes, the SYSMODE byte and the DIP-switch bank. It holds the core in reset while a ROM image is loading and for a fixed hold-off afterwards, and it folds the user reset sources into that same reset. It sits in the top level between `hps_io` and `SEGASYSTEM1`, replacing the ad-hoc `ioctl_*` decode and `iRST` logic.

## Interface
Parameters:
- `ROM_INDEX`, 8'd0: ioctl index carrying the ROM image.
- `MODE_INDEX`, 8'd1: ioctl index whose byte 0 is SYSMODE.
- `DSW_INDEX`, 8'd254: ioctl index carrying DIP bytes 0..7.
- `HOLD_CYC`, 1024: core-reset hold-off in clk_sys cycles after a load or user reset; must be ≥ 2.

Ports:
- `clk_sys` in 1: single clock, 48 MHz.
- `reset_n` in 1: asynchronous, active-low reset.
- `ioctl_download` in 1: download in progress.
- `ioctl_wr` in 1: byte strobe, one cycle.
- `ioctl_index` in 8: stream selector.
- `ioctl_addr` in 25: byte address.
- `ioctl_dout` in 8: byte data.
- `user_reset` in 1: level; OR of menu reset and the board button.
- `rom_we` out 1: ROM write strobe to the core (`ROMEN`).
- `rom_addr` out 25: ROM write address.
- `rom_data` out 8: ROM write data.
- `sysmode` out 8: [0] SYS1/SYS2, [1] H/V, [2] H256/H240.
- `dsw` out 64: byte k at [8k+7:8k]; core uses bytes 0 and 1.
- `core_reset` out 1: active-high reset to the game core.
- `ready` out 1: at least one complete ROM load has finished.

## Operation
- States: BOOT, LOAD, HOLD, RUN. Async reset enters BOOT.
- Reset values: `core_reset`=1, `ready`=0, `rom_we`=0, `rom_addr`=0, `rom_data`=0, `sysmode`=0, `dsw`=0, hold counter=0.
- A "ROM download" means `ioctl_download`=1 and `ioctl_index`=ROM_INDEX.
- BOOT: `core_reset`=1. Go to LOAD on a ROM download. No other event leaves BOOT.
- LOAD: `core_reset`=1. When `ioctl_download` falls, clear the counter, set `ready`=1 and go to HOLD.
- HOLD: `core_reset`=1 and the counter increments each cycle. When the counter reaches HOLD_CYC-1, go to RUN.
- HOLD, ROM download begins: go to LOAD; the counter is cleared on the next HOLD entry.
- HOLD, `user_reset`=1: clear the counter; stay in HOLD.
- RUN: `core_reset`=0.
- RUN, ROM download: go to LOAD.
- RUN, `user_reset`=1: clear the counter and go to HOLD. While `user_reset` stays high the counter is held at 0.
- `user_reset` in BOOT or LOAD is ignored.
- Write demux applies to `ioctl_wr`=1 with `ioctl_download`=1, in any state; strobes with `ioctl_download`=0 are ignored.
  - index ROM_INDEX: `rom_we`/`rom_addr`/`rom_data` ← 1/`ioctl_addr`/`ioctl_dout`.
  - index MODE_INDEX, addr 0: `sysmode` ← `ioctl_dout`.
  - index DSW_INDEX, addr[24:3]=0: byte addr[2:0] of `dsw` ← `ioctl_dout`.
  - any other index or address: no effect.
- SYSMODE and DSW downloads never change state or `core_reset`; new values reach the running core live.
- `ready` is sticky until `reset_n`.

## Timing
- `rom_we`, `rom_addr`, `rom_data`: registered, 1 cycle after `ioctl_wr`. `rom_we` is a 1-cycle pulse; `rom_addr`/`rom_data` hold their last value.
- `sysmode`/`dsw`: updated 1 cycle after the strobe.
- `core_reset`: registered from state.
  - Falls exactly HOLD_CYC+1 cycles after `ioctl_download` falls, with no intervening events.
  - Rises 1 cycle after `user_reset` is sampled high in RUN.
- ROM download start in RUN: `core_reset` rises 1 cycle after `ioctl_download` is sampled with ROM_INDEX.
- Back-to-back `ioctl_wr` on consecutive cycles is supported with no dropped bytes.
- Simultaneous `user_reset` and ROM download start in RUN or HOLD: LOAD wins.

## Structure
- Shared package `segasys1_pkg`:
  - state enum `load_state_t`.
  - SYSMODE bit-position constants.
  - default index constants.
- One sub-module, `ioctl_demux`: registered write decode for ROM, SYSMODE and DSW.
- State machine and hold counter (width `$clog2(HOLD_CYC)`) stay in the top module.

## Test plan
- Reset, then ROM download of 4 bytes (addr 0..3, data A0..A3), then `ioctl_download` falls → 4 `rom_we` pulses each lagging by 1 cycle; `ready`=1; `core_reset` falls HOLD_CYC+1 cycles after download end.
- Index 1, addr 0 = 8'h06 and index 254, addr 2 = 8'h5A during RUN → `sysmode`=8'h06, `dsw`[23:16]=8'h5A, `core_reset` stays 0, `rom_we` never pulses.
- `user_reset` held 10 cycles in RUN → `core_reset` rises after 1 cycle and falls HOLD_CYC+1 cycles after `user_reset` drops.
- ROM download restarted mid-HOLD → returns to LOAD; a full HOLD_CYC hold-off follows the second download.
- `ioctl_wr` pulses with `ioctl_download`=0, plus index 254 addr 8 → no output change.
- `reset_n` asserted mid-LOAD → all outputs return to reset values immediately; state is BOOT and `ready`=0.
